// File: rtl/vga_frame_reader.sv
// VGA raster reader: walks the frame buffer through the RAM's display port and
// serialises 64-bit words into 8-bit pixels with hsync/vsync/de aligned 3 clks behind the counters.
module vga_frame_reader #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] fb_base,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [7:0]            pixel,
   output logic                  de,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0]         H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0]         V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0]         H_ACT      = HW'(H_ACTIVE);
   localparam logic [VW-1:0]         V_ACT      = VW'(V_ACTIVE);
   localparam logic [HW-1:0]         HS_START   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]         HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0]         VS_START   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]         VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [ADDR_WIDTH-1:0] LINE_WORDS = ADDR_WIDTH'(H_ACTIVE / 8);

   logic [HW-1:0]         h_cnt_q, h_cnt_d;
   logic [VW-1:0]         v_cnt_q, v_cnt_d;
   logic [ADDR_WIDTH-1:0] frame_base_q, frame_base_d;
   logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [ADDR_WIDTH-1:0] cur_base;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [7:0]            pixel_q, pixel_d, pix_src;
   logic [2:0]            de_p_q, de_p_d;
   logic [2:0]            hs_p_q, hs_p_d;
   logic [2:0]            vs_p_q, vs_p_d;
   logic [2:0]            fs_p_q, fs_p_d;
   logic [1:0]            fetch_p_q, fetch_p_d;
   logic                  active, hsync_raw, vsync_raw, frame_top, line_end, fetch;

   always_comb begin
      line_end  = (h_cnt_q == H_LAST);
      frame_top = (h_cnt_q == '0) && (v_cnt_q == '0);
      active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hsync_raw = !((h_cnt_q >= HS_START) && (h_cnt_q <= HS_END));
      vsync_raw = !((v_cnt_q >= VS_START) && (v_cnt_q <= VS_END));
      fetch     = active && (h_cnt_q[2:0] == 3'd0);

      h_cnt_d = line_end ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (line_end) begin
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end

      // The very first fetch of a frame must see the base being latched on the same edge.
      frame_base_d = frame_top ? fb_base : frame_base_q;
      if (v_cnt_q == '0) begin
         cur_base = (h_cnt_q == '0) ? fb_base : frame_base_q;
      end else begin
         cur_base = line_base_q;
      end

      line_base_d = line_base_q;
      if (line_end) begin
         line_base_d = ((v_cnt_q == '0) ? frame_base_q : line_base_q) + LINE_WORDS;
      end

      mem_addr_d = fetch ? cur_base + ADDR_WIDTH'(h_cnt_q[HW-1:3]) : mem_addr_q;

      de_p_d    = {de_p_q[1:0], active};
      hs_p_d    = {hs_p_q[1:0], hsync_raw};
      vs_p_d    = {vs_p_q[1:0], vsync_raw};
      fs_p_d    = {fs_p_q[1:0], frame_top};
      fetch_p_d = {fetch_p_q[0], fetch};

      // A fresh word's first byte goes straight to the pixel register so the lag stays at 3.
      if (fetch_p_q[1]) begin
         pix_src = mem_rdata[7:0];
         shift_d = mem_rdata >> 8;
      end else begin
         pix_src = shift_q[7:0];
         shift_d = shift_q >> 8;
      end
      pixel_d = de_p_q[1] ? pix_src : 8'h00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q      <= '0;
         v_cnt_q      <= '0;
         frame_base_q <= '0;
         line_base_q  <= '0;
         mem_addr_q   <= '0;
         shift_q      <= '0;
         pixel_q      <= '0;
         de_p_q       <= '0;
         hs_p_q       <= '1;
         vs_p_q       <= '1;
         fs_p_q       <= '0;
         fetch_p_q    <= '0;
      end else begin
         h_cnt_q      <= h_cnt_d;
         v_cnt_q      <= v_cnt_d;
         frame_base_q <= frame_base_d;
         line_base_q  <= line_base_d;
         mem_addr_q   <= mem_addr_d;
         shift_q      <= shift_d;
         pixel_q      <= pixel_d;
         de_p_q       <= de_p_d;
         hs_p_q       <= hs_p_d;
         vs_p_q       <= vs_p_d;
         fs_p_q       <= fs_p_d;
         fetch_p_q    <= fetch_p_d;
      end
   end

   assign mem_addr    = mem_addr_q;
   assign pixel       = pixel_q;
   assign de          = de_p_q[2];
   assign hsync       = hs_p_q[2];
   assign vsync       = vs_p_q[2];
   assign frame_start = fs_p_q[2];

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader on a shrunken raster, with a behavioural display-port RAM
// and a reference raster model feeding an expected-output queue.
module tb_vga_frame_reader;

   localparam int HA = 32, HFP = 4, HS = 8, HBP = 4;
   localparam int VA = 6, VFP = 2, VS = 2, VBP = 2;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;
   localparam int W = HA / 8;
   localparam logic [11:0] RST_EXP = {8'h00, 1'b0, 1'b1, 1'b1, 1'b0};

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] fb_base;
   logic [31:0] mem_addr;
   logic [63:0] mem_rdata;
   logic [7:0]  pixel;
   logic        de, hsync, vsync, frame_start;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   vga_frame_reader #(
      .DATA_WIDTH(64), .ADDR_WIDTH(32),
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .fb_base(fb_base), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .pixel(pixel), .de(de), .hsync(hsync),
      .vsync(vsync), .frame_start(frame_start)
   );

   // RAM contents: byte k of word a is {a[4:0], k}, so word 0x1000 = 0x0706050403020100.
   function automatic logic [63:0] word_of(input logic [31:0] a);
      logic [63:0] w;
      for (int k = 0; k < 8; k++) w[8*k +: 8] = {a[4:0], 3'(k)};
      return w;
   endfunction

   logic [31:0] ram_addr_q = 32'h0;
   always @(posedge clk) ram_addr_q <= mem_addr;
   assign mem_rdata = word_of(ram_addr_q);

   // Reference raster model: one expectation per counter cycle, two reset entries pre-loaded.
   logic [11:0] exp_q[$];
   logic [11:0] cur_exp;
   int          mh, mv;
   logic [31:0] mbase, exp_addr;

   always @(posedge clk or negedge rst_n) begin : model
      logic [31:0] base, waddr;
      logic [63:0] w;
      logic        e_de, e_hs, e_vs, e_fs;
      logic [7:0]  e_pix;
      if (!rst_n) begin
         mh <= 0; mv <= 0; mbase <= 32'h0; exp_addr <= 32'h0;
         exp_q.delete();
         exp_q.push_back(RST_EXP);
         exp_q.push_back(RST_EXP);
      end else begin
         base  = (mh == 0 && mv == 0) ? fb_base : mbase;
         waddr = base + 32'(mv * W + mh / 8);
         w     = word_of(waddr);
         e_de  = (mh < HA) && (mv < VA);
         e_hs  = !((mh >= HA + HFP) && (mh < HA + HFP + HS));
         e_vs  = !((mv >= VA + VFP) && (mv < VA + VFP + VS));
         e_fs  = (mh == 0) && (mv == 0);
         e_pix = e_de ? w[8*(mh%8) +: 8] : 8'h00;
         mbase <= base;
         if (e_de && (mh % 8 == 0)) exp_addr <= waddr;
         exp_q.push_back({e_pix, e_de, e_hs, e_vs, e_fs});
         if (mh == HT - 1) begin
            mh <= 0;
            mv <= (mv == VT - 1) ? 0 : mv + 1;
         end else begin
            mh <= mh + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: actual still running, required finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic test_reset;
      rst_n   = 1'b0;
      fb_base = 32'h1000;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         checks++;
         if ({pixel, de, hsync, vsync, frame_start} !== cur_exp) begin
            fails++;
            $display("[TB] FAIL reset_stream: actual %h required %h", {pixel, de, hsync, vsync, frame_start}, cur_exp);
         end
         checks++;
         if (mem_addr !== exp_addr) begin
            fails++;
            $display("[TB] FAIL reset_stream_addr: actual %h required %h", mem_addr, exp_addr);
         end
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pixel, de, hsync, vsync, frame_start} !== RST_EXP) begin
         fails++;
         $display("[TB] FAIL async_reset_outputs: actual %h required %h", {pixel, de, hsync, vsync, frame_start}, RST_EXP);
      end
      checks++;
      if (mem_addr !== 32'h0) begin
         fails++;
         $display("[TB] FAIL async_reset_addr: actual %h required 00000000", mem_addr);
      end
      #1 rst_n = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk); #1;
         checks++;
         if (frame_start !== (n == 3)) begin
            fails++;
            $display("[TB] FAIL frame_start_edge%0d: actual %b required %b", n, frame_start, (n == 3));
         end
      end
   endtask

   task automatic test_frame;
      int de_hi = 0, hs_lo = 0, vs_lo = 0;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk); #1;
         if (de)     de_hi++;
         if (!hsync) hs_lo++;
         if (!vsync) vs_lo++;
         checks++;
         if ({pixel, de, hsync, vsync, frame_start} !== cur_exp) begin
            fails++;
            $display("[TB] FAIL frame_stream h=%0d v=%0d: actual %h required %h", mh, mv, {pixel, de, hsync, vsync, frame_start}, cur_exp);
         end
         checks++;
         if (mem_addr !== exp_addr) begin
            fails++;
            $display("[TB] FAIL frame_addr h=%0d v=%0d: actual %h required %h", mh, mv, mem_addr, exp_addr);
         end
      end
      checks++;
      if (de_hi != HA * VA) begin
         fails++;
         $display("[TB] FAIL de_count: actual %0d required %0d", de_hi, HA * VA);
      end
      checks++;
      if (hs_lo != HS * VT) begin
         fails++;
         $display("[TB] FAIL hsync_count: actual %0d required %0d", hs_lo, HS * VT);
      end
      checks++;
      if (vs_lo != VS * HT) begin
         fails++;
         $display("[TB] FAIL vsync_count: actual %0d required %0d", vs_lo, VS * HT);
      end
   endtask

   task automatic test_base_shadow;
      int  budget;
      bit  reached;
      for (int phase = 0; phase < 2; phase++) begin
         budget  = 0;
         reached = 1'b0;
         while (!reached && budget < 2 * FRAME) begin
            @(negedge clk); #1;
            budget++;
            checks++;
            if ({pixel, de, hsync, vsync, frame_start} !== cur_exp) begin
               fails++;
               $display("[TB] FAIL shadow_stream h=%0d v=%0d: actual %h required %h", mh, mv, {pixel, de, hsync, vsync, frame_start}, cur_exp);
            end
            checks++;
            if (mem_addr !== exp_addr) begin
               fails++;
               $display("[TB] FAIL shadow_addr h=%0d v=%0d: actual %h required %h", mh, mv, mem_addr, exp_addr);
            end
            reached = (phase == 0) ? (mv == 2) : (mh == 1 && mv == 0);
         end
         checks++;
         if (!reached) begin
            fails++;
            $display("[TB] FAIL shadow_wait%0d: actual timeout required position reached", phase);
         end
         if (phase == 0) fb_base = 32'h2000;
      end
      checks++;
      if (mem_addr !== 32'h2000) begin
         fails++;
         $display("[TB] FAIL shadow_next_frame_addr: actual %h required 00002000", mem_addr);
      end
   endtask

   task automatic test_midframe_reset;
      int budget = 0;
      while (mv != 4 && budget < 2 * FRAME) begin
         @(negedge clk); #1;
         budget++;
         checks++;
         if ({pixel, de, hsync, vsync, frame_start} !== cur_exp) begin
            fails++;
            $display("[TB] FAIL pre_reset_stream: actual %h required %h", {pixel, de, hsync, vsync, frame_start}, cur_exp);
         end
      end
      checks++;
      if (mv != 4) begin
         fails++;
         $display("[TB] FAIL midframe_wait: actual v=%0d required v=4", mv);
      end
      fb_base = 32'h3000;
      rst_n   = 1'b0;
      #1;
      checks++;
      if ({de, hsync, vsync, mem_addr} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
         fails++;
         $display("[TB] FAIL midframe_reset_state: actual de=%b hs=%b vs=%b addr=%h required de=0 hs=1 vs=1 addr=0", de, hsync, vsync, mem_addr);
      end
      #1 rst_n = 1'b1;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk); #1;
         if (i == 0) begin
            checks++;
            if (mem_addr !== 32'h3000) begin
               fails++;
               $display("[TB] FAIL restart_first_addr: actual %h required 00003000", mem_addr);
            end
         end
         checks++;
         if ({pixel, de, hsync, vsync, frame_start} !== cur_exp) begin
            fails++;
            $display("[TB] FAIL restart_stream h=%0d v=%0d: actual %h required %h", mh, mv, {pixel, de, hsync, vsync, frame_start}, cur_exp);
         end
         checks++;
         if (mem_addr !== exp_addr) begin
            fails++;
            $display("[TB] FAIL restart_addr h=%0d v=%0d: actual %h required %h", mh, mv, mem_addr, exp_addr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_base_shadow();
      test_midframe_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
